// File: rtl/mem_stage.sv
// Memory-access stage: decodes the XM latch, runs a req/ack data-memory access
// while holding the pipeline, then loads the MW latch with the result.
module mem_stage #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [31:0]       xm_ir,
    input  logic [31:0]       xm_result,
    input  logic [31:0]       xm_dataB,
    input  logic              xm_exception,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       mw_ir,
    output logic [31:0]       mw_data,
    output logic              mw_exception
);
    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [7:0] LAST  = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, nxt;
    logic [7:0]  cnt, cnt_d;
    logic        is_lw, is_sw, addr_ok, mem_op, start;
    logic [31:0] mw_ir_d, mw_data_d;
    logic        mw_exc_d;

    assign is_lw   = (xm_ir[31:27] == OP_LW);
    assign is_sw   = (xm_ir[31:27] == OP_SW);
    assign addr_ok = (xm_result[31:ADDR_W] == '0);
    assign mem_op  = (is_lw | is_sw) & ~xm_exception & addr_ok;
    assign mem_req = (state == ACCESS);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= nxt;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        nxt       = state;
        cnt_d     = cnt;
        stall     = 1'b0;
        start     = 1'b0;
        mw_ir_d   = xm_ir;
        mw_data_d = xm_result;
        mw_exc_d  = xm_exception;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall     = 1'b1;
                    start     = 1'b1;
                    nxt       = ACCESS;
                    cnt_d     = 8'd0;
                    mw_ir_d   = '0;
                    mw_data_d = '0;
                    mw_exc_d  = 1'b0;
                end else if ((is_lw | is_sw) & ~xm_exception) begin
                    // out-of-range address: no access, flag it downstream
                    mw_data_d = '0;
                    mw_exc_d  = 1'b1;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    nxt       = IDLE;
                    mw_data_d = mem_we ? xm_result : mem_rdata;
                    mw_exc_d  = 1'b0;
                end else if (cnt < LAST) begin
                    stall     = 1'b1;
                    cnt_d     = cnt + 8'd1;
                    mw_ir_d   = '0;
                    mw_data_d = '0;
                    mw_exc_d  = 1'b0;
                end else begin
                    // timeout abort: release the pipeline with an exception
                    nxt       = IDLE;
                    mw_data_d = '0;
                    mw_exc_d  = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            mem_we    <= is_sw;
            mem_addr  <= xm_result[ADDR_W-1:0];
            mem_wdata <= xm_dataB;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mw_ir        <= '0;
            mw_data      <= '0;
            mw_exception <= 1'b0;
        end else begin
            mw_ir        <= mw_ir_d;
            mw_data      <= mw_data_d;
            mw_exception <= mw_exc_d;
        end
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage sitting on the output of the execute/memory pipeline latch. It decodes the latched instruction and issues a load or store to data memory over a req/ack handshake. While the access is outstanding it freezes the upstream pipeline. It then loads the memory/writeback latch with the instruction, the write-back data and the exception flag.

## Interface
Parameters:
- ADDR_W, 12, data-memory word-address width.
- TIMEOUT, 16, maximum ACCESS cycles to wait for mem_ack before aborting (legal range 2..255).

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- xm_ir  in  32  latched instruction; opcode xm_ir[31:27]; 0 = nop.
- xm_result  in  32  latched ALU result; effective address for lw/sw.
- xm_dataB  in  32  latched store data.
- xm_exception  in  1  latched exception flag.
- stall  out  1  hold request; upstream drives latch enables with ~stall.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDR_W  word address, xm_result[ADDR_W-1:0].
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data, valid in the mem_ack cycle.
- mem_ack  in  1  single-cycle completion strobe.
- mw_ir  out  32  registered instruction to writeback.
- mw_data  out  32  registered write-back data.
- mw_exception  out  1  registered exception flag.

## Operation
- Opcode decode: lw = 5'b01000, sw = 5'b00111; every other opcode is non-memory.
- mem_op = (lw | sw) & ~xm_exception & addr_ok.
- addr_ok = (xm_result[31:ADDR_W] == 0).
- FSM has two states, IDLE and ACCESS.
- IDLE, non-mem_op: stall=0. Next edge loads mw_ir<=xm_ir, mw_data<=xm_result, mw_exception<=xm_exception.
- IDLE, lw/sw with ~addr_ok and ~xm_exception: no access, stall=0. Next edge loads mw_ir<=xm_ir, mw_data<=0, mw_exception<=1.
- IDLE, mem_op:
  - stall=1 (combinational).
  - Next edge: state<=ACCESS; mem_addr, mem_we, mem_wdata registered from the XM inputs; timeout counter<=0.
  - The MW latch loads a bubble (all zero).
- ACCESS: mem_req=1, with addr/we/wdata held constant.
- ACCESS with mem_ack=1: stall=0 in the same cycle. Next edge:
  - state<=IDLE, mem_req drops.
  - mw_ir<=xm_ir; mw_exception<=0.
  - mw_data<=mem_rdata for lw, xm_result for sw.
- ACCESS, no ack, counter < TIMEOUT-1: stall=1, counter increments, MW latch loads a bubble.
- ACCESS, no ack, counter == TIMEOUT-1: abort. stall=0 in that cycle. Next edge:
  - state<=IDLE.
  - mw_ir<=xm_ir, mw_data<=0, mw_exception<=1.
- mem_ack is ignored in IDLE; a late ack after abort has no effect.
- The counter is 8 bits wide and never wraps; it is only meaningful in ACCESS.

## Timing
- Reset (clr_n low, asynchronous):
  - state=IDLE, counter=0.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - mw_ir, mw_data, mw_exception = 0.
  - stall follows decode of the current inputs in IDLE.
- Reset mid-ACCESS drops mem_req immediately. No MW write occurs for the aborted instruction.
- Non-memory latency: 1 cycle, no stall.
- Memory latency: 1 detect cycle (stall=1) + N ACCESS cycles, where ack arrives in ACCESS cycle N.
  - Stall cycles = N.
  - The MW result appears at the edge ending the ack cycle.
- Minimum load/store: ack in the first ACCESS cycle gives 1 stall cycle and 2-cycle latency.
- Timeout: TIMEOUT ACCESS cycles with no ack, stall high for TIMEOUT cycles total.
- stall is combinational from state, xm_ir, xm_result, xm_exception, mem_ack and counter. mem_req is a Moore output.
- Back-to-back memory ops: the instruction after an ack is seen in IDLE the next cycle. Its detect cycle follows with no idle gap.

## Test plan
- Reset, then xm_ir=add (opcode 0), xm_result=32'h5 → stall=0; next edge mw_ir=add, mw_data=5, mw_exception=0.
- lw with xm_result=12'h010, memory acks in the 3rd ACCESS cycle with mem_rdata=32'hDEADBEEF:
  - stall high for exactly 3 cycles; mem_req high for 3 cycles with mem_addr=12'h010, mem_we=0.
  - MW loads bubbles while stalled, then mw_data=32'hDEADBEEF.
- sw with xm_result=12'h004, xm_dataB=32'h1234, ack in the 1st ACCESS cycle:
  - mem_we=1, mem_wdata=32'h1234, stall high for 1 cycle.
  - Then mw_data=32'h004, mw_exception=0.
- lw with no ack, TIMEOUT=4:
  - stall high 4 cycles, mem_req high 4 cycles.
  - Then mw_exception=1, mw_data=0.
  - An ack injected 2 cycles later is ignored.
- Rejected accesses, no mem_req, stall=0, both with mw_exception=1 next edge:
  - lw with xm_result=32'h0001_0000, out of range: mw_data=0.
  - sw with xm_exception=1: mw_data=xm_result.
- clr_n pulsed low in the 2nd ACCESS cycle:
  - mem_req and all mw_* outputs 0 immediately.
  - After release, state is IDLE and the next instruction is processed normally.
